// File: rtl/img_rsz_pkg.sv
// img_rsz_pkg: shared types, constants and helpers for the resizer frame arbiter
package img_rsz_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} ImgRszArbSt_t;
  localparam logic [31:0] SIZE_RST = '1;
  function automatic int nxt_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/img_rsz_rr_arb.sv
// img_rsz_rr_arb: combinational round-robin picker starting at ptr
module img_rsz_rr_arb
  import img_rsz_pkg::*;
#(
  parameter int SRC_NUM   = 2,
  parameter int SRC_IDX_W = $clog2(SRC_NUM)
) (
  input  logic [SRC_NUM-1:0]   req,
  input  logic [SRC_IDX_W-1:0] ptr,
  output logic [SRC_IDX_W-1:0] win,
  output logic                 vld
);
  logic [2*SRC_NUM-1:0] rot;
  assign rot = {req, req} >> ptr;
  assign vld = |req;
  // lowest rotated offset wins, so scan from the far end and let nearer hits overwrite
  always_comb begin
    win = '0;
    for (int k = SRC_NUM - 1; k >= 0; k--)
      if (rot[k]) win = SRC_IDX_W'((int'(ptr) + k) % SRC_NUM);
  end
endmodule

// File: rtl/img_rsz_frm_arb.sv
// img_rsz_frm_arb: frame-granular round-robin arbiter feeding one resizer capture stage
module img_rsz_frm_arb
  import img_rsz_pkg::*;
#(
  parameter int SRC_NUM            = 2,
  parameter int IMG_WIDTH_IDX_W    = 10,
  parameter int IMG_HEIGHT_IDX_W   = 10,
  parameter int PXL_PRIM_COLOR_NUM = 1,
  parameter int PXL_PRIM_COLOR_W   = 8,
  parameter int SRC_IDX_W          = $clog2(SRC_NUM)
) (
  input  logic                                                               Clk,
  input  logic                                                               Reset,
  input  logic [SRC_NUM-1:0]                                                 SrcFrmReq,
  input  logic [SRC_NUM-1:0][IMG_WIDTH_IDX_W-1:0]                            SrcImgWidth,
  input  logic [SRC_NUM-1:0][IMG_HEIGHT_IDX_W-1:0]                           SrcImgHeight,
  input  logic [SRC_NUM-1:0][PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]   SrcPxlData,
  input  logic [SRC_NUM-1:0][IMG_WIDTH_IDX_W-1:0]                            SrcPxlX,
  input  logic [SRC_NUM-1:0][IMG_HEIGHT_IDX_W-1:0]                           SrcPxlY,
  input  logic [SRC_NUM-1:0]                                                 SrcPxlVld,
  output logic [SRC_NUM-1:0]                                                 SrcPxlRdy,
  output logic [SRC_NUM-1:0]                                                 SrcFrmGnt,
  output logic [SRC_NUM-1:0]                                                 SrcFrmDone,
  output logic [SRC_NUM-1:0]                                                 SrcFrmErr,
  output logic [IMG_WIDTH_IDX_W-1:0]                                         ImgWidth,
  output logic [IMG_HEIGHT_IDX_W-1:0]                                        ImgHeight,
  output logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]                PxlData,
  output logic [IMG_WIDTH_IDX_W-1:0]                                         PxlX,
  output logic [IMG_HEIGHT_IDX_W-1:0]                                        PxlY,
  output logic                                                               PxlVld,
  input  logic                                                               PxlRdy,
  input  logic                                                               RszImgComp,
  output logic                                                               ProtErr,
  output logic                                                               Busy
);
  ImgRszArbSt_t                state;
  logic [SRC_IDX_W-1:0]        ptr, gnt_idx, win;
  logic                        win_vld, size_ok, xfer, last, comp;
  logic [SRC_NUM-1:0]          gnt_oh;
  logic [IMG_WIDTH_IDX_W-1:0]  hor_cnt;
  logic [IMG_HEIGHT_IDX_W-1:0] ver_cnt;

  img_rsz_rr_arb #(.SRC_NUM(SRC_NUM), .SRC_IDX_W(SRC_IDX_W)) u_arb (
    .req(SrcFrmReq),
    .ptr(ptr),
    .win(win),
    .vld(win_vld)
  );

  assign size_ok   = (|SrcImgWidth[win]) && (|SrcImgHeight[win]);
  assign gnt_oh    = SRC_NUM'(1) << gnt_idx;
  assign PxlVld    = (state == STREAM) && SrcPxlVld[gnt_idx];
  assign SrcPxlRdy = (state == STREAM && PxlRdy) ? gnt_oh : '0;
  assign PxlData   = SrcPxlData[gnt_idx];
  assign PxlX      = SrcPxlX[gnt_idx];
  assign PxlY      = SrcPxlY[gnt_idx];
  assign xfer      = PxlVld && PxlRdy;
  assign last      = xfer && hor_cnt == ImgWidth - 1'b1 && ver_cnt == ImgHeight - 1'b1;
  assign comp      = RszImgComp && (state == DRAIN || last);
  assign Busy      = state != IDLE;

  // frame FSM: arbitrate in IDLE, count raster transfers in STREAM, wait for completion in DRAIN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_idx    <= '0;
      SrcFrmGnt  <= '0;
      SrcFrmDone <= '0;
      SrcFrmErr  <= '0;
      ProtErr    <= 1'b0;
      ImgWidth   <= IMG_WIDTH_IDX_W'(SIZE_RST);
      ImgHeight  <= IMG_HEIGHT_IDX_W'(SIZE_RST);
      hor_cnt    <= '0;
      ver_cnt    <= '0;
    end else begin
      SrcFrmDone <= '0;
      SrcFrmErr  <= '0;
      if (RszImgComp && !comp) ProtErr <= 1'b1;
      if (state == IDLE) begin
        SrcFrmGnt <= '0;
        if (win_vld && size_ok) begin
          state     <= STREAM;
          gnt_idx   <= win;
          SrcFrmGnt <= SRC_NUM'(1) << win;
          ImgWidth  <= SrcImgWidth[win];
          ImgHeight <= SrcImgHeight[win];
          hor_cnt   <= '0;
          ver_cnt   <= '0;
        end else if (win_vld) begin
          SrcFrmErr <= SRC_NUM'(1) << win;
          ptr       <= SRC_IDX_W'(nxt_idx(int'(win), SRC_NUM));
        end
      end
      if (comp) begin
        state      <= IDLE;
        SrcFrmDone <= gnt_oh;
        ptr        <= SRC_IDX_W'(nxt_idx(int'(gnt_idx), SRC_NUM));
      end else if (last) begin
        state <= DRAIN;
      end else if (xfer) begin
        hor_cnt <= (hor_cnt == ImgWidth - 1'b1) ? '0 : hor_cnt + 1'b1;
        ver_cnt <= (hor_cnt == ImgWidth - 1'b1) ? ver_cnt + 1'b1 : ver_cnt;
      end
    end
  end
endmodule
